// File: rtl/mult8x8.sv
// 8x8 unsigned multiplier: eight AND-gated partial products reduced by a carry-save tree
// of full adders, then a 16-bit ripple carry-propagate adder; optional output register.
module mult8x8 #(
    parameter int unsigned OUT_REG = 1
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        in_valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    output logic [15:0] out
);

    // {carry, sum}
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // 3:2 compressor over 16-bit rows, returns {carry_row, sum_row}. Every row is
    // non-negative and the rows always add up to a*b < 2^16, so no row can carry past bit 15.
    function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
        logic [15:0] s;
        logic [15:0] c;
        logic [1:0]  r;
        c    = '0;
        s    = '0;
        for (int i = 0; i < 15; i++) begin
            r        = full_add(x[i], y[i], z[i]);
            s[i]     = r[0];
            c[i + 1] = r[1];
        end
        s[15] = x[15] ^ y[15] ^ z[15];
        return {c, s};
    endfunction

    logic [15:0] pp [8];
    logic [15:0] s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;
    logic [15:0] product;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp[i] = b[i] ? ({8'b0, a} << i) : 16'h0000;
        end
    end

    // Reduction 8 -> 6 -> 4 -> 3 -> 2 rows
    always_comb begin
        {c1, s1} = csa(pp[0], pp[1], pp[2]);
        {c2, s2} = csa(pp[3], pp[4], pp[5]);
        {c3, s3} = csa(s1, c1, s2);
        {c4, s4} = csa(c2, pp[6], pp[7]);
        {c5, s5} = csa(s3, c3, s4);
        {c6, s6} = csa(s5, c5, c4);
    end

    always_comb begin
        logic cy;
        logic [1:0] r;
        product = '0;
        r          = half_add(s6[0], c6[0]);
        product[0] = r[0];
        cy         = r[1];
        for (int i = 1; i < 16; i++) begin
            r          = full_add(s6[i], c6[i], cy);
            product[i] = r[0];
            cy         = r[1];
        end
    end

    if (OUT_REG != 0) begin : g_reg
        logic [15:0] out_q;
        logic        vld_q;

        always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn) begin
                out_q <= 16'h0000;
                vld_q <= 1'b0;
            end else begin
                vld_q <= in_valid;
                if (in_valid) begin
                    out_q <= product;
                end
            end
        end

        assign out       = out_q;
        assign out_valid = vld_q;
    end else begin : g_comb
        // Stateless: reset only masks the valid flag.
        assign out       = product;
        assign out_valid = in_valid & nvdla_core_rstn;
    end

endmodule

// File: tb/tb_mult8x8.sv
// Bench for mult8x8: registered and combinational instances share the stimulus; a queue
// scoreboard holds the expected registered result of each driven cycle.
module tb_mult8x8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        reg_vld;
    logic [15:0] reg_out;
    logic        comb_vld;
    logic [15:0] comb_out;

    typedef struct packed {
        logic        v;
        logic [15:0] p;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_out;
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    always #5 clk = ~clk;

    mult8x8 #(.OUT_REG(1)) u_dut_reg (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .in_valid        (in_valid),
        .a               (a),
        .b               (b),
        .out_valid       (reg_vld),
        .out             (reg_out)
    );

    mult8x8 #(.OUT_REG(0)) u_dut_comb (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .in_valid        (in_valid),
        .a               (a),
        .b               (b),
        .out_valid       (comb_vld),
        .out             (comb_out)
    );

    task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (a=%h b=%h t=%0t)", tag, got, exp, a, b,
                     $time);
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase of the next cycle.
    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        logic [15:0] p;
        p        = {8'b0, x} * {8'b0, y};
        in_valid = v;
        a        = x;
        b        = y;
        if (v) model_out = p;
        e.v = v;
        e.p = model_out;
        sb.push_back(e);
        #1;
        check_eq("comb", {comb_vld, comb_out}, {v, p});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 17'(sb.size()), 17'd1);
        end else begin
            e = sb.pop_front();
            check_eq("reg", {reg_vld, reg_out}, {e.v, e.p});
        end
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b1;
        a         = 8'hFF;
        b         = 8'hFF;
        model_out = 16'h0000;
        #3;
        check_eq("rst_reg", {reg_vld, reg_out}, 17'd0);
        check_eq("rst_comb_vld", {16'd0, comb_vld}, 17'd0);
        @(posedge clk);
        #1;
        check_eq("rst_hold", {reg_vld, reg_out}, 17'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        drive(1'b1, 8'hFF, 8'hFF);
        check_eq("max", {reg_vld, reg_out}, {1'b1, 16'hFE01});
        drive(1'b1, 8'h12, 8'h34);
        check_eq("v12x34", {1'b0, reg_out}, {1'b0, 16'h03A8});
        drive(1'b1, 8'h80, 8'h02);
        check_eq("v80x02", {1'b0, reg_out}, {1'b0, 16'h0100});
        drive(1'b1, 8'h00, 8'h5A);
        check_eq("zero", {1'b0, reg_out}, {1'b0, 16'h0000});

        drive(1'b1, 8'h03, 8'h05);
        check_eq("b2b0", {reg_vld, reg_out}, {1'b1, 16'h000F});
        drive(1'b1, 8'h10, 8'h10);
        check_eq("b2b1", {reg_vld, reg_out}, {1'b1, 16'h0100});
        drive(1'b1, 8'hAA, 8'h55);
        check_eq("b2b2", {reg_vld, reg_out}, {1'b1, 16'h3872});

        drive(1'b1, 8'h07, 8'h09);
        drive(1'b0, 8'hFF, 8'hFF);
        check_eq("hold", {reg_vld, reg_out}, {1'b0, 16'h003F});

        // Asynchronous reset while the max product is showing
        drive(1'b1, 8'hFF, 8'hFF);
        check_eq("pre_rst", {reg_vld, reg_out}, {1'b1, 16'hFE01});
        #2;
        rstn = 1'b0;
        #1;
        check_eq("async_rst", {reg_vld, reg_out}, 17'd0);
        check_eq("async_rst_comb", {16'd0, comb_vld}, 17'd0);
        @(posedge clk);
        #1;
        check_eq("rst_edge", {reg_vld, reg_out}, 17'd0);
        rstn      = 1'b1;
        model_out = 16'h0000;
        sb.delete();
        drive(1'b0, 8'h00, 8'h00);
        check_eq("no_stale", {reg_vld, reg_out}, 17'd0);
        drive(1'b1, 8'h02, 8'h03);
        check_eq("post_rst", {reg_vld, reg_out}, {1'b1, 16'h0006});

        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, i[15:8], i[7:0]);
        end

        repeat (2000) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mult8x8.md
MULT8X8 -- requirements
Module: mult8x8

Interface
REQ-001 Parameter OUT_REG, default 1, SHALL select the output mode: 1 = registered output with one-cycle latency, 0 = purely combinational output.
REQ-002 Port nvdla_core_clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port nvdla_core_rstn, input, 1 bit, SHALL be the reset, asynchronous and active-low.
REQ-004 Port in_valid, input, 1 bit, SHALL qualify a and b as a valid operand pair in the current cycle.
REQ-005 Port a, input, 8 bits, SHALL be the unsigned multiplicand.
REQ-006 Port b, input, 8 bits, SHALL be the unsigned multiplier.
REQ-007 Port out_valid, output, 1 bit, SHALL indicate that out holds the product of a valid operand pair.
REQ-008 Port out, output, 16 bits, SHALL be the unsigned product a*b.

Function
REQ-009 The product SHALL be exact unsigned arithmetic: out = a*b, range 0x0000..0xFE01, with no truncation, rounding or approximation.
REQ-010 The datapath SHALL form eight partial products pp[i] = (b[i] ? a : 0) << i, for i = 0..7.
REQ-011 The partial products SHALL be summed by an explicit adder tree of full and half adders (carry-save reduction followed by a final 16-bit carry-propagate adder), not by a behavioural multiply operator.
REQ-012 All internal sums SHALL be wide enough that no carry is lost; bit 15 of out is the final carry-out.
REQ-013 With OUT_REG=1, a pair sampled on rising edge N SHALL appear on out at edge N, i.e. valid from edge N to edge N+1.
REQ-014 With OUT_REG=1, out_valid SHALL be the registered in_valid.
REQ-015 With OUT_REG=1, the out register SHALL load only when in_valid=1 and SHALL hold its previous value when in_valid=0.
REQ-016 With OUT_REG=0, out SHALL equal a*b combinationally in the same cycle, and out_valid SHALL equal in_valid.
REQ-017 Back-to-back valid pairs on consecutive cycles SHALL each produce their own product on consecutive cycles, with no bubbles and no stall.
REQ-018 There is no backpressure; the block SHALL always accept input.
REQ-019 Operands SHALL be treated as unsigned; sign handling is the caller's responsibility (the caller passes magnitudes).

Reset
REQ-020 While nvdla_core_rstn=0, out SHALL be 0x0000 and out_valid SHALL be 0, asserted asynchronously without waiting for a clock edge.
REQ-021 A reset asserted mid-operation SHALL discard any product in flight; no stale product SHALL appear after reset is released.
REQ-022 After reset is released, the first valid pair sampled SHALL produce its product one cycle later (OUT_REG=1).
REQ-023 With OUT_REG=0 there is no state, and reset SHALL affect only out_valid, which is forced to 0.

Verification
REQ-024 a=0xFF, b=0xFF, in_valid=1 -> next cycle out=0xFE01, out_valid=1.
REQ-025 a=0x12, b=0x34 -> out=0x03A8; a=0x80, b=0x02 -> out=0x0100; a=0x00, b=0x5A -> out=0x0000.
REQ-026 Back-to-back pairs (0x03,0x05), (0x10,0x10), (0xAA,0x55) on three consecutive cycles -> out=0x000F, 0x0100, 0x3872 on the following three cycles.
REQ-027 in_valid=1 with 0x07*0x09, then in_valid=0 with a=0xFF, b=0xFF -> out stays 0x003F, out_valid drops to 0.
REQ-028 Reset asserted between clock edges while out=0xFE01 -> out=0x0000 and out_valid=0 immediately; after release, 0x02*0x03 -> out=0x0006 one cycle later.
REQ-029 Random and exhaustive sweep of all 65536 operand pairs in both OUT_REG modes -> every out matches the a*b reference model.
